cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
Frame-capture sequencer between the camera pixel interface and a ping-pong frame BRAM (two buffers of COLS*ROWS pixels). It arms on a software start, aligns to the next frame start, and generates the BRAM write address, enable and data for one full frame. It then reports completion and swaps buffers, unless the consumer still holds the other buffer. Single-shot and continuous modes; all logic on PCLK.

Parameters:
COLS, 640, active pixels per line
ROWS, 480, active lines per frame
PIX_W, 8, pixel data width
ADDR_W, 19, pixel address width; must satisfy 2**ADDR_W >= COLS*ROWS

Ports:
PCLK  in  1  camera pixel clock
reset  in  1  synchronous, active-high
vsync  in  1  frame valid, active high, PCLK-synchronous
hsync  in  1  line valid, active high, PCLK-synchronous
din  in  PIX_W  pixel data, valid when hsync&vsync
start  in  1  one-cycle pulse: arm capture
stop  in  1  one-cycle pulse: stop after current frame
continuous  in  1  1 = re-arm after each frame; sampled at start and at frame end
rd_busy  in  1  consumer is reading buffer ~buf_sel
wr_addr  out  ADDR_W+1  {buf_sel, pixel index} to BRAM port A
wr_data  out  PIX_W  registered din
wr_en  out  1  BRAM write enable
buf_sel  out  1  buffer currently being written
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of captured frame
done_buf  out  1  buffer completed; valid with frame_done
frame_err  out  1  sticky: last frame pixel count != COLS*ROWS
frame_cnt  out  16  completed frames, wraps
drop_cnt  out  8  swaps withheld due to rd_busy, saturates at 255

Behaviour:
- Reset values: all outputs 0. State IDLE, pixel counter 0. vsync_q = 1, so vsync high at reset release is not a SOF.
- SOF = vsync & ~vsync_q. EOF = ~vsync & vsync_q. pix_valid = vsync & hsync.
- States:
  - IDLE: start -> WAIT_SOF. Start together with stop in IDLE: stay IDLE.
  - WAIT_SOF: stop -> IDLE. SOF -> CAPTURE; clear pixel counter and frame_err.
  - CAPTURE: on EOF -> DONE. stop only sets a pending-stop flag.
  - DONE: lasts 1 cycle.
    - If pending stop or continuous=0 -> IDLE.
    - Else -> WAIT_SOF.
- The SOF cycle's pixel is captured if pix_valid. Capture is never partial: arming mid-frame waits for the next SOF.
- Write pipeline, latency 1: in CAPTURE with pix_valid and counter < COLS*ROWS, the next cycle has wr_en=1, wr_data=din, and wr_addr={buf_sel, counter}. The counter then increments. Otherwise wr_en=0 next cycle.
- Overrun: pixels beyond COLS*ROWS are not written; frame_err set.
- Short frame: counter < COLS*ROWS at EOF sets frame_err.
- DONE cycle:
  - frame_done=1, done_buf=buf_sel, frame_cnt += 1 (wraps 0xFFFF->0).
  - If rd_busy=0: buf_sel toggles.
  - If rd_busy=1: buf_sel holds (next frame overwrites the same buffer) and drop_cnt += 1, saturating.
- start in any state other than IDLE is ignored. stop in IDLE is ignored.
- frame_err is sticky until the next SOF in CAPTURE entry or reset.
- Reset mid-frame: immediate return to reset values. The in-flight write is abandoned (wr_en=0 the next cycle).
- Counter width is ADDR_W. Compare against the constant COLS*ROWS computed at ADDR_W+1 bits.

Decomposition:
- Package cam_pkg holds:
  - cap_state_t enum {IDLE, WAIT_SOF, CAPTURE, DONE}
  - defaults CAM_COLS=640, CAM_ROWS=480
  - function frame_pix(COLS, ROWS)
- Sub-module cam_sync_edge: registers vsync, outputs sof/eof pulses, resets vsync_q to 1. Reusable by the decoder and timing checkers.

Test Plan:
- COLS=4, ROWS=2; start, then one clean frame of 8 pixels din=0x10..0x17 with continuous=0 -> 8 wr_en pulses at addr 0..7 in buffer 0, data 0x10..0x17. frame_done once with done_buf=0, buf_sel=1, frame_cnt=1, frame_err=0, state IDLE.
- Start asserted mid-frame while vsync high -> no writes until next SOF. The next full frame is captured at addresses 0..7.
- continuous=1, three frames with rd_busy=0 -> buffer order 0,1,0. After the 3rd, frame_cnt=3 and buf_sel=1.
- continuous=1, rd_busy=1 at second frame end -> buf_sel not toggled; drop_cnt=1; third frame rewrites the same buffer.
- Frame of 10 valid pixels -> only 8 writes, frame_err=1. Frame of 5 pixels -> frame_err=1. A following clean frame clears frame_err.
- stop during CAPTURE -> current frame completes with frame_done, then IDLE. Reset mid-CAPTURE -> wr_en=0, busy=0 the next cycle, all counters 0.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and helpers for the camera capture sequencer
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam int CAM_COLS = 640;
    localparam int CAM_ROWS = 480;

    // Number of active pixels in one frame
    function automatic int unsigned frame_pix(input int unsigned cols, input int unsigned rows);
        return cols * rows;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - vsync edge detector producing start/end-of-frame pulses
module cam_sync_edge (
    input  logic PCLK,
    input  logic reset,
    input  logic vsync_i,
    output logic sof_o,
    output logic eof_o
);

    logic vsync_q;

    // Previous vsync; resets high so a frame already in progress is not a SOF
    always_ff @(posedge PCLK) begin
        if (reset) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync_i;
        end
    end

    assign sof_o = vsync_i & ~vsync_q;
    assign eof_o = ~vsync_i & vsync_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - ping-pong frame capture sequencer driving BRAM port A
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int COLS   = CAM_COLS,
    parameter int ROWS   = CAM_ROWS,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
) (
    input  logic              PCLK,
    input  logic              reset,
    input  logic              vsync,
    input  logic              hsync,
    input  logic [PIX_W-1:0]  din,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic              rd_busy,
    output logic [ADDR_W:0]   wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              wr_en,
    output logic              buf_sel,
    output logic              busy,
    output logic              frame_done,
    output logic              done_buf,
    output logic              frame_err,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W+1)'(frame_pix(COLS, ROWS));

    cap_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d, cur_cnt;
    logic               buf_q, buf_d;
    logic               err_q, err_d;
    logic               stop_pend_q, stop_pend_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [7:0]         drop_q, drop_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W:0]    wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]   wr_data_q, wr_data_d;
    logic               sof, eof, pix_valid, capture_px;

    cam_sync_edge u_sync (
        .PCLK    (PCLK),
        .reset   (reset),
        .vsync_i (vsync),
        .sof_o   (sof),
        .eof_o   (eof)
    );

    assign pix_valid = vsync & hsync;

    // Next-state, pixel write pipeline and frame bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        err_d       = err_q;
        stop_pend_d = stop_pend_q;
        frame_cnt_d = frame_cnt_q;
        drop_d      = drop_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        capture_px  = 1'b0;
        // The SOF cycle writes pixel 0 even though the counter clears in the same cycle
        cur_cnt     = (state_q == WAIT_SOF) ? '0 : cnt_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (sof) begin
                    state_d     = CAPTURE;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    stop_pend_d = 1'b0;
                    capture_px  = pix_valid;
                end
            end
            CAPTURE: begin
                capture_px = pix_valid;
                if (stop) stop_pend_d = 1'b1;
                if (eof) begin
                    state_d = DONE;
                    if ({1'b0, cnt_q} < FRAME_PIX) err_d = 1'b1;
                end
            end
            DONE: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (rd_busy) begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end else begin
                    buf_d = ~buf_q;
                end
                stop_pend_d = 1'b0;
                state_d     = (stop_pend_q || stop || !continuous) ? IDLE : WAIT_SOF;
            end
            default: state_d = IDLE;
        endcase

        if (capture_px) begin
            if ({1'b0, cur_cnt} < FRAME_PIX) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {buf_q, cur_cnt};
                wr_data_d = din;
                cnt_d     = cur_cnt + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge PCLK) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            buf_q       <= 1'b0;
            err_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            frame_cnt_q <= '0;
            drop_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            err_q       <= err_d;
            stop_pend_q <= stop_pend_d;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign buf_sel    = buf_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign done_buf   = (state_q == DONE) & buf_q;
    assign frame_err  = err_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - scoreboard bench for cam_capture_ctrl
module tb_cam_capture_ctrl;

    localparam int COLS   = 4;
    localparam int ROWS   = 2;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 4;
    localparam int NPIX   = COLS * ROWS;

    logic              PCLK = 1'b0;
    logic              reset = 1'b1;
    logic              vsync = 1'b0;
    logic              hsync = 1'b0;
    logic [PIX_W-1:0]  din = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic              rd_busy = 1'b0;
    logic [ADDR_W:0]   wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_en;
    logic              buf_sel;
    logic              busy;
    logic              frame_done;
    logic              done_buf;
    logic              frame_err;
    logic [15:0]       frame_cnt;
    logic [7:0]        drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+PIX_W:0] wq[$];
    logic [1:0]            dq[$];

    cam_capture_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
    ) dut (
        .PCLK(PCLK), .reset(reset), .vsync(vsync), .hsync(hsync), .din(din),
        .start(start), .stop(stop), .continuous(continuous), .rd_busy(rd_busy),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .buf_sel(buf_sel),
        .busy(busy), .frame_done(frame_done), .done_buf(done_buf),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 PCLK = ~PCLK;

    // Monitor: every write and every frame_done must match the next expected entry
    always @(negedge PCLK) begin
        logic [ADDR_W+PIX_W:0] ew;
        logic [1:0]            ed;
        if (wr_en) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0h data=%0h expected none", wr_addr, wr_data);
            end else begin
                ew = wq.pop_front();
                if ({wr_addr, wr_data} !== ew) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%0h expected addr=%0h data=%0h",
                             wr_addr, wr_data, ew[ADDR_W+PIX_W:PIX_W], ew[PIX_W-1:0]);
                end
            end
        end
        if (frame_done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got done_buf=%0d expected none", done_buf);
            end else begin
                ed = dq.pop_front();
                if ({done_buf, frame_err} !== ed) begin
                    errors++;
                    $display("FAIL done got done_buf=%0d frame_err=%0d expected done_buf=%0d frame_err=%0d",
                             done_buf, frame_err, ed[1], ed[0]);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
    endtask

    // Expected writes and completion for one captured frame
    task automatic expect_frame(input logic b, input int n, input logic [7:0] base, input logic err);
        logic [ADDR_W-1:0] idx;
        for (int i = 0; i < n && i < NPIX; i++) begin
            idx = ADDR_W'(i);
            wq.push_back({b, idx, base + 8'(i)});
        end
        dq.push_back({b, err});
    endtask

    // Drive a frame of n valid pixels in COLS-wide lines; optional stop pulse on pixel stop_at
    task automatic send_frame(input int n, input logic [7:0] base, input int stop_at);
        int sent = 0;
        vsync = 1'b1;
        while (sent < n) begin
            for (int c = 0; c < COLS && sent < n; c++) begin
                hsync = 1'b1;
                din   = base + 8'(sent);
                stop  = (sent == stop_at);
                tick(1);
                sent++;
            end
            hsync = 1'b0;
            stop  = 1'b0;
            tick(2);
        end
        vsync = 1'b0;
        tick(4);
    endtask

    initial begin
        tick(2);
        do_reset();
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_buf_sel", buf_sel, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_frame_err", frame_err, 0);

        // Single clean frame into buffer 0
        continuous = 1'b0;
        pulse_start();
        check("armed_busy", busy, 1);
        expect_frame(1'b0, 8, 8'h10, 1'b0);
        send_frame(8, 8'h10, -1);
        check("t1_buf_sel", buf_sel, 1);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_frame_err", frame_err, 0);
        check("t1_idle", busy, 0);

        // Arm mid-frame: that frame is skipped, next one captured into buffer 1
        vsync = 1'b1;
        tick(1);
        start = 1'b1;
        hsync = 1'b1;
        din = 8'hEE;
        tick(1);
        start = 1'b0;
        tick(3);
        hsync = 1'b0;
        vsync = 1'b0;
        tick(3);
        expect_frame(1'b1, 8, 8'h20, 1'b0);
        send_frame(8, 8'h20, -1);
        check("t2_buf_sel", buf_sel, 0);
        check("t2_frame_cnt", frame_cnt, 2);

        // Continuous, three frames, buffers 0,1,0
        do_reset();
        continuous = 1'b1;
        pulse_start();
        expect_frame(1'b0, 8, 8'h30, 1'b0);
        send_frame(8, 8'h30, -1);
        expect_frame(1'b1, 8, 8'h38, 1'b0);
        send_frame(8, 8'h38, -1);
        expect_frame(1'b0, 8, 8'h40, 1'b0);
        send_frame(8, 8'h40, -1);
        check("t3_frame_cnt", frame_cnt, 3);
        check("t3_buf_sel", buf_sel, 1);
        check("t3_still_armed", busy, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        check("t3_stop_wait_sof", busy, 0);

        // rd_busy at second frame end withholds the swap
        do_reset();
        continuous = 1'b1;
        pulse_start();
        expect_frame(1'b0, 8, 8'h50, 1'b0);
        send_frame(8, 8'h50, -1);
        rd_busy = 1'b1;
        expect_frame(1'b1, 8, 8'h58, 1'b0);
        send_frame(8, 8'h58, -1);
        rd_busy = 1'b0;
        check("t4_buf_held", buf_sel, 1);
        check("t4_drop_cnt", drop_cnt, 1);
        continuous = 1'b0;
        expect_frame(1'b1, 8, 8'h60, 1'b0);
        send_frame(8, 8'h60, -1);
        check("t4_frame_cnt", frame_cnt, 3);
        check("t4_buf_sel", buf_sel, 0);
        check("t4_idle", busy, 0);

        // Overrun, short frame, then a clean frame clears the error
        do_reset();
        continuous = 1'b0;
        pulse_start();
        expect_frame(1'b0, 10, 8'h70, 1'b1);
        send_frame(10, 8'h70, -1);
        check("t5_overrun_err", frame_err, 1);
        pulse_start();
        expect_frame(1'b1, 5, 8'h80, 1'b1);
        send_frame(5, 8'h80, -1);
        check("t5_short_err", frame_err, 1);
        pulse_start();
        expect_frame(1'b0, 8, 8'h90, 1'b0);
        send_frame(8, 8'h90, -1);
        check("t5_err_cleared", frame_err, 0);
        check("t5_frame_cnt", frame_cnt, 3);

        // Stop during capture completes the frame then idles
        continuous = 1'b1;
        pulse_start();
        expect_frame(1'b1, 8, 8'hA0, 1'b0);
        send_frame(8, 8'hA0, 3);
        check("t6_idle", busy, 0);
        check("t6_frame_cnt", frame_cnt, 4);
        send_frame(8, 8'hB0, -1);
        check("t6_buf_sel", buf_sel, 0);

        // Reset in the middle of a capture
        continuous = 1'b0;
        pulse_start();
        wq.push_back({1'b0, 4'd0, 8'hC0});
        wq.push_back({1'b0, 4'd1, 8'hC1});
        vsync = 1'b1;
        hsync = 1'b1;
        din = 8'hC0;
        tick(1);
        din = 8'hC1;
        tick(1);
        din = 8'hC2;
        reset = 1'b1;
        tick(1);
        check("t7_wr_en", wr_en, 0);
        check("t7_busy", busy, 0);
        check("t7_frame_cnt", frame_cnt, 0);
        check("t7_drop_cnt", drop_cnt, 0);
        check("t7_buf_sel", buf_sel, 0);
        reset = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        tick(3);

        check("writes_consumed", wq.size(), 0);
        check("dones_consumed", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
